// File: rtl/horner_frame_loader.sv
// horner_frame_loader: ping-pong input frame loader for the 32-channel Horner evaluator.
// Samples arrive over valid/ready and fill one bank while the sequencer
// reads the other bank by channel index. Each completed frame launches
// with a one-cycle srdyi pulse; back-to-back launches follow srdyo.
module horner_frame_loader #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 32
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              srdyi,
  input  logic              srdyo,
  input  logic [4:0]        channel_select,
  output logic [DATA_W-1:0] sample_out,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  // State encoding is exactly {fill_full, busy}, so the flags fall out of the state bits.
  typedef enum logic [1:0] {
    FILL_IDLE = 2'b00,
    FILL_BUSY = 2'b01,
    LAUNCH    = 2'b10,
    HOLD      = 2'b11
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_CH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [4:0]        r_wr_cnt;
  logic              r_srdyi;
  logic              r_fill_sel;
  logic [15:0]       r_frame_cnt;
  logic [DATA_W-1:0] r_bank0 [NUM_CH];
  logic [DATA_W-1:0] r_bank1 [NUM_CH];

  logic              w_fill_full;
  logic              w_busy;
  logic              w_accept;
  logic              w_last;
  logic              w_launch;
  logic [NUM_CH-1:0] w_we0;
  logic [NUM_CH-1:0] w_we1;

  assign w_fill_full = r_state[1];
  assign w_busy      = r_state[0];
  // Ready depends on registered state only, never on din_valid.
  assign w_accept    = din_valid && !w_fill_full;
  assign w_last      = (r_wr_cnt == LAST_IDX);

  // Per-entry write enables: only the fill bank is ever written.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_we
    assign w_we0[gi] = w_accept && !r_fill_sel && (r_wr_cnt == 5'(gi));
    assign w_we1[gi] = w_accept &&  r_fill_sel && (r_wr_cnt == 5'(gi));
  end

  // State register for the fill/compute handshake FSM.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state <= FILL_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and launch decode; srdyo while idle is ignored, and srdyo
  // together with the 32nd accept goes through LAUNCH on the following edge.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (w_accept && w_last) w_state_next = LAUNCH;
      end
      FILL_BUSY: begin
        if (w_accept && w_last) w_state_next = srdyo ? LAUNCH : HOLD;
        else if (srdyo)         w_state_next = FILL_IDLE;
      end
      HOLD: begin
        if (srdyo) begin
          w_launch     = 1'b1;
          w_state_next = FILL_BUSY;
        end
      end
      LAUNCH: begin
        w_launch     = 1'b1;
        w_state_next = FILL_BUSY;
      end
      default: w_state_next = FILL_IDLE;
    endcase
  end

  // Write pointer, bank select, launch pulse and frame counter.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_wr_cnt    <= '0;
      r_srdyi     <= 1'b0;
      r_fill_sel  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_srdyi <= w_launch;
      if (w_accept) begin
        r_wr_cnt <= w_last ? 5'd0 : r_wr_cnt + 5'd1;
      end
      if (w_launch) begin
        r_fill_sel  <= !r_fill_sel;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Bank storage; cleared on reset so the compute bank reads zero before the first launch.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_we0[i]) r_bank0[i] <= din;
        if (w_we1[i]) r_bank1[i] <= din;
      end
    end
  end

  assign din_ready  = !w_fill_full;
  assign srdyi      = r_srdyi;
  assign busy       = w_busy;
  assign frame_cnt  = r_frame_cnt;
  // Compute bank is the one not being filled.
  assign sample_out = r_fill_sel ? r_bank0[channel_select] : r_bank1[channel_select];

endmodule

// File: tb/tb_horner_frame_loader.sv
// Self-checking bench for horner_frame_loader: directed sequences, a channel
// sweep table, and randomized traffic checked against a queue-based model.
module tb_horner_frame_loader;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          srdyi;
  logic          srdyo;
  logic [4:0]    channel_select;
  logic [DW-1:0] sample_out;
  logic          busy;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  horner_frame_loader #(.DATA_W(DW), .NUM_CH(32)) dut (
    .clk            (clk),
    .GlobalReset    (GlobalReset),
    .din            (din),
    .din_valid      (din_valid),
    .din_ready      (din_ready),
    .srdyi          (srdyi),
    .srdyo          (srdyo),
    .channel_select (channel_select),
    .sample_out     (sample_out),
    .busy           (busy),
    .frame_cnt      (frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: words accepted into the pending frame, the frame being
  // computed, and the sequencer-visible flags.
  logic [31:0] fill_q[$];
  logic [31:0] m_cur [32];
  bit          m_busy;
  bit          m_srdyi;
  int          m_cnt;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    fill_q.delete();
    for (int k = 0; k < 32; k++) m_cur[k] = '0;
    m_busy  = 0;
    m_srdyi = 0;
    m_cnt   = 0;
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s.din_ready", tag), 32'(din_ready), 32'(fill_q.size() < 32));
    check($sformatf("%s.srdyi", tag), 32'(srdyi), 32'(m_srdyi));
    check($sformatf("%s.busy", tag), 32'(busy), 32'(m_busy));
    check($sformatf("%s.frame_cnt", tag), 32'(frame_cnt), 32'(m_cnt & 16'hFFFF));
    check($sformatf("%s.sample_out", tag), sample_out, m_cur[channel_select]);
  endtask

  // Advance one clock: evaluate the rules on the pre-edge inputs, update the
  // model at the edge, then compare 1 time unit after the edge.
  task automatic do_cycle(input string tag);
    bit lau;
    bit acc;
    lau = (fill_q.size() == 32) && (!m_busy || srdyo);
    acc = din_valid && (fill_q.size() < 32);
    @(posedge clk);
    if (lau) begin
      for (int k = 0; k < 32; k++) m_cur[k] = fill_q[k];
      fill_q.delete();
      m_busy  = 1;
      m_srdyi = 1;
      m_cnt++;
      $display("frame %0d launched, first word %h", m_cnt, m_cur[0]);
    end else begin
      m_srdyi = 0;
      if (srdyo) m_busy = 0;
      if (acc) fill_q.push_back(din);
    end
    #1;
    compare_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    GlobalReset    = 1'b0;
    din            = '0;
    din_valid      = 1'b0;
    srdyo          = 1'b0;
    channel_select = '0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.din_ready", 32'(din_ready), 32'd1);
    check("rst.srdyi", 32'(srdyi), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst.sample_out", sample_out, 32'd0);
    #2 GlobalReset = 1'b1;

    // Single frame, compute idle
    for (int i = 0; i < 32; i++) begin
      din       = 32'h100 + 32'(i);
      din_valid = 1'b1;
      do_cycle("fill1");
    end
    check("f1.ready_after_32nd", 32'(din_ready), 32'd0);
    check("f1.srdyi_at_32nd", 32'(srdyi), 32'd0);
    din_valid = 1'b0;
    do_cycle("launch1");
    check("f1.srdyi_pulse", 32'(srdyi), 32'd1);
    check("f1.busy", 32'(busy), 32'd1);
    check("f1.frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1.ready_back", 32'(din_ready), 32'd1);
    do_cycle("post1");
    check("f1.srdyi_one_cycle", 32'(srdyi), 32'd0);

    // Channel sweep table
    for (int k = 0; k < 32; k++) begin
      tbl[k].sel = 5'(k);
      tbl[k].exp = 32'h100 + 32'(k);
    end
    for (int k = 0; k < 32; k++) begin
      channel_select = tbl[k].sel;
      #1;
      check($sformatf("sweep1[%0d]", k), sample_out, tbl[k].exp);
    end

    // Backpressure: second frame fills with the sequencer still busy
    for (int i = 0; i < 32; i++) begin
      din       = 32'h200 + 32'(i);
      din_valid = 1'b1;
      do_cycle("fill2");
    end
    for (int i = 0; i < 5; i++) begin
      din = 32'hDEAD_0000 + 32'(i);
      do_cycle("stall");
    end
    check("bp.din_ready", 32'(din_ready), 32'd0);
    check("bp.srdyi", 32'(srdyi), 32'd0);
    channel_select = 5'd3;
    #1;
    check("bp.sample_frame1", sample_out, 32'h103);
    din_valid = 1'b0;

    // Back-to-back launch on srdyo
    srdyo = 1'b1;
    do_cycle("b2b");
    srdyo = 1'b0;
    check("b2b.srdyi", 32'(srdyi), 32'd1);
    check("b2b.busy", 32'(busy), 32'd1);
    check("b2b.frame_cnt", 32'(frame_cnt), 32'd2);
    check("b2b.din_ready", 32'(din_ready), 32'd1);
    channel_select = 5'd9;
    #1;
    check("b2b.sample_frame2", sample_out, 32'h209);

    // srdyo finishes frame 2, then a stray srdyo while idle is ignored
    srdyo = 1'b1;
    do_cycle("finish2");
    srdyo = 1'b0;
    check("idle.busy_cleared", 32'(busy), 32'd0);
    srdyo = 1'b1;
    do_cycle("stray");
    srdyo = 1'b0;
    check("stray.busy", 32'(busy), 32'd0);
    check("stray.frame_cnt", 32'(frame_cnt), 32'd2);
    check("stray.srdyi", 32'(srdyi), 32'd0);

    // Input gaps: ~50% valid with a known pattern
    for (int c = 0; c < 400 && m_cnt < 3; c++) begin
      din_valid      = 1'($urandom_range(0, 1));
      din            = 32'h300 + 32'(c);
      channel_select = 5'($urandom);
      do_cycle("gaps");
    end
    din_valid = 1'b0;
    check("gaps.frame_cnt", 32'(frame_cnt), 32'd3);
    for (int k = 0; k < 32; k++) begin
      channel_select = 5'(k);
      #1;
      check($sformatf("sweep3[%0d]", k), sample_out, m_cur[k]);
    end

    // Reset mid-frame: 17 accepted, then asynchronous reset between edges
    for (int i = 0; i < 17; i++) begin
      din       = 32'h400 + 32'(i);
      din_valid = 1'b1;
      do_cycle("fill17");
    end
    din_valid      = 1'b0;
    channel_select = 5'd2;
    @(posedge clk);
    #3 GlobalReset = 1'b0;
    #1;
    check("arst.din_ready", 32'(din_ready), 32'd1);
    check("arst.srdyi", 32'(srdyi), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.frame_cnt", 32'(frame_cnt), 32'd0);
    check("arst.sample_out", sample_out, 32'd0);
    model_reset();
    @(posedge clk);
    #3 GlobalReset = 1'b1;

    for (int i = 0; i < 31; i++) begin
      din       = 32'h500 + 32'(i);
      din_valid = 1'b1;
      do_cycle("refill");
    end
    check("refill.no_launch_at_31", 32'(frame_cnt), 32'd0);
    din = 32'h51F;
    do_cycle("refill32");
    din_valid = 1'b0;
    do_cycle("relaunch");
    check("relaunch.srdyi", 32'(srdyi), 32'd1);
    check("relaunch.frame_cnt", 32'(frame_cnt), 32'd1);
    channel_select = 5'd31;
    #1;
    check("relaunch.ch31", sample_out, 32'h51F);
    channel_select = 5'd0;
    #1;
    check("relaunch.ch0", sample_out, 32'h500);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      din_valid      = 1'($urandom_range(0, 1));
      din            = $urandom;
      srdyo          = ($urandom_range(0, 5) == 0);
      channel_select = 5'($urandom);
      do_cycle("rand");
    end
    srdyo     = 1'b0;
    din_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
